// File: rtl/point_referee_pkg.sv
// Shared pong definitions: game state encoding and screen/ball geometry
// used by the referee and by the ball, paddle and score drawers.
package point_referee_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        SCORED,
        GAMEOVER
    } state_t;

    localparam int SCREEN_W     = 640;
    localparam int BALL_SIZE    = 10;
    localparam int LEFT_LIMIT   = 0;
    localparam int SERVE_FRAMES = 60;
    localparam int CNT_W        = 6;

endpackage

// File: rtl/point_referee_frame_delay_counter.sv
// Counts frame ticks while the ball is held for a serve; done fires on the
// tick that completes the hold so the caller can leave SERVE on that edge.
module frame_delay_counter #(
    parameter int SERVE_FRAMES = 60,
    parameter int CNT_W        = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic frame_tick,
    output logic done
);

    if ((2 ** CNT_W) <= SERVE_FRAMES) begin : g_cnt_w_check
        $error("CNT_W too narrow for SERVE_FRAMES");
    end

    logic [CNT_W-1:0] cnt;

    // Combinational so the owner sees completion in the same cycle as the tick.
    assign done = frame_tick && !clear && (cnt == CNT_W'(SERVE_FRAMES - 1));

    // Clear dominates; completion wraps back to zero for the next serve.
    always_ff @(posedge clk) begin
        if (!rst)                cnt <= '0;
        else if (clear || done)  cnt <= '0;
        else if (frame_tick)     cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/point_referee.sv
// Pong referee: detects edge goals, issues one-cycle point pulses, runs the
// serve hold and stops play once either score renderer reports game over.
module point_referee
    import point_referee_pkg::*;
#(
    parameter int SCREEN_W     = point_referee_pkg::SCREEN_W,
    parameter int BALL_SIZE    = point_referee_pkg::BALL_SIZE,
    parameter int LEFT_LIMIT   = point_referee_pkg::LEFT_LIMIT,
    parameter int SERVE_FRAMES = point_referee_pkg::SERVE_FRAMES,
    parameter int CNT_W        = point_referee_pkg::CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       over_l,
    input  logic       over_r,
    output logic       win_rst_l,
    output logic       win_rst_r,
    output logic       score_clr,
    output logic       ball_rst,
    output logic       serve_dir,
    output logic       game_over
);

    state_t state, state_n;
    logic   win_l_n, win_r_n, clr_n, dir_n;
    logic   cnt_clr, serve_done;
    logic   hit_l, hit_r;
    logic [10:0] right_edge;

    // Row position is reserved for future lane checks.
    logic unused_ball_y;
    assign unused_ball_y = ^ball_y;

    // 11-bit sum so a ball near column 1023 cannot wrap back on-screen.
    assign right_edge = {1'b0, ball_x} + 11'(BALL_SIZE);
    assign hit_l      = (ball_x <= 10'(LEFT_LIMIT));
    assign hit_r      = (right_edge >= 11'(SCREEN_W));

    // Counter runs only inside SERVE; a game-over flag also discards the count.
    assign cnt_clr = (state != SERVE) || over_l || over_r;

    frame_delay_counter #(
        .SERVE_FRAMES (SERVE_FRAMES),
        .CNT_W        (CNT_W)
    ) u_delay (
        .clk        (clk),
        .rst        (rst),
        .clear      (cnt_clr),
        .frame_tick (frame_tick),
        .done       (serve_done)
    );

    // Next state and next pulse values; outputs are registered from these.
    always_comb begin
        state_n = state;
        win_l_n = 1'b0;
        win_r_n = 1'b0;
        clr_n   = 1'b0;
        dir_n   = serve_dir;
        case (state)
            IDLE: begin
                if (start_btn) begin
                    clr_n   = 1'b1;
                    state_n = SERVE;
                end
            end
            SERVE: begin
                if (over_l || over_r) state_n = GAMEOVER;
                else if (serve_done)  state_n = PLAY;
            end
            PLAY: begin
                // Left edge wins a simultaneous hit so only one pulse goes out.
                if (hit_l) begin
                    win_r_n = 1'b1;
                    dir_n   = 1'b0;
                    state_n = SCORED;
                end else if (hit_r) begin
                    win_l_n = 1'b1;
                    dir_n   = 1'b1;
                    state_n = SCORED;
                end
            end
            // One-cycle gap lets the renderer's over flag settle before SERVE.
            SCORED: state_n = SERVE;
            GAMEOVER: begin
                if (start_btn) begin
                    clr_n   = 1'b1;
                    state_n = SERVE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; ball_rst/game_over follow the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            win_rst_l <= 1'b0;
            win_rst_r <= 1'b0;
            score_clr <= 1'b0;
            ball_rst  <= 1'b1;
            serve_dir <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_n;
            win_rst_l <= win_l_n;
            win_rst_r <= win_r_n;
            score_clr <= clr_n;
            ball_rst  <= (state_n != PLAY);
            serve_dir <= dir_n;
            game_over <= (state_n == GAMEOVER);
        end
    end

endmodule

// File: doc/point_referee.md
Name: point_referee

Overview:
- Upstream of the per-player score digit renderers; produces the one-cycle point pulses they count.
- Watches the ball position each clock and detects goals at the left and right screen edges.
- Runs the serve/hold sequence: holds the ball at centre for a fixed number of frames, then releases it.
- Stops play once either score renderer reports game over, and restarts the match on the start button.

Parameters:
- SCREEN_W, 640, visible width in pixels.
- BALL_SIZE, 10, ball edge length in pixels.
- LEFT_LIMIT, 0, a ball_x at or below this value is a left-edge goal.
- SERVE_FRAMES, 60, number of frame_tick pulses the ball is held before release.
- CNT_W, 6, serve counter width; must satisfy 2^CNT_W > SERVE_FRAMES.

Ports:
- clk  in  1  system pixel clock.
- rst  in  1  synchronous reset, active-low. One clock domain; all state updates on posedge clk.
- ball_x  in  10  ball left-edge column.
- ball_y  in  10  ball top row; carried for future lane checks and unused for scoring.
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank).
- start_btn  in  1  debounced, level-sensitive start/restart button.
- over_l  in  1  game-over flag from the left player's score renderer.
- over_r  in  1  game-over flag from the right player's score renderer.
- win_rst_l  out  1  one-cycle point pulse to the left player's score renderer.
- win_rst_r  out  1  one-cycle point pulse to the right player's score renderer.
- score_clr  out  1  one-cycle active-high clear to both score renderers.
- ball_rst  out  1  high while the ball is held at centre.
- serve_dir  out  1  0 = serve toward the left, 1 = serve toward the right.
- game_over  out  1  high in GAMEOVER.

Behaviour:
- All outputs are registered.
- Reset values (while rst == 0): state IDLE, serve counter 0, win_rst_l 0, win_rst_r 0, score_clr 0, ball_rst 1, serve_dir 0, game_over 0.
- IDLE: ball_rst = 1. start_btn == 1 -> pulse score_clr for one cycle, clear the counter, go to SERVE.
- SERVE: ball_rst = 1.
  - Counter increments on each frame_tick.
  - The cycle on which a frame_tick takes the counter to SERVE_FRAMES: clear the counter, go to PLAY. ball_rst drops on that transition edge.
  - If over_l or over_r is high in SERVE -> go to GAMEOVER. This check has priority over counter completion.
- PLAY: ball_rst = 0.
  - ball_x <= LEFT_LIMIT -> pulse win_rst_r, set serve_dir = 0 (serve toward the player who conceded), go to SCORED.
  - Else ball_x + BALL_SIZE >= SCREEN_W -> pulse win_rst_l, set serve_dir = 1, go to SCORED.
  - Compute the right-edge sum at 11 bits so it cannot wrap.
  - If both conditions are true in the same cycle, the left-edge condition wins; exactly one pulse is issued.
- SCORED: lasts exactly one cycle. ball_rst = 1, pulses already deasserted, counter cleared, go to SERVE.
  - The one-cycle gap guarantees the renderer's registered over flag is valid before SERVE samples it.
- GAMEOVER: game_over = 1, ball_rst = 1. start_btn == 1 -> pulse score_clr, clear game_over, go to SERVE.
- Pulse rules:
  - win_rst_l and win_rst_r are never high in the same cycle.
  - Each goal produces exactly one pulse, even if the ball stays past the edge; the ball is held by ball_rst after the pulse.
  - No pulse is ever issued outside PLAY.
- frame_tick arriving in the same cycle as the SERVE entry edge is not counted.
- Counter saturation is unreachable by construction; the parameter check on CNT_W guards it.
- rst low in any state: return to reset values on the next edge. Any in-flight pulse is truncated and no pulse is re-issued.
- start_btn held high continuously: score_clr pulses only on IDLE/GAMEOVER exit, never repeatedly.

Decomposition:
- Shared pong package: state enum {IDLE, SERVE, PLAY, SCORED, GAMEOVER}, SCREEN_W, BALL_SIZE.
- These are shared with the ball, paddle and score drawers.
- One natural sub-module: frame_delay_counter.
  - Inputs: clk, rst, clear, frame_tick.
  - Output: done when the count reaches SERVE_FRAMES.
- The FSM and edge compare stay in point_referee.

Test Plan:
- Reset then hold rst high with start_btn = 0 for 100 cycles -> ball_rst = 1; win_rst_l, win_rst_r, score_clr = 0; game_over = 0.
- start_btn pulse -> score_clr high for exactly 1 cycle. Then 60 frame_ticks (SERVE_FRAMES = 60) -> ball_rst falls on the 60th tick's edge, not earlier.
- In PLAY, drive ball_x = 0 for 5 cycles -> win_rst_r high exactly 1 cycle, serve_dir = 0, ball_rst = 1 from the next cycle. Drive ball_x = 630 in a new PLAY -> win_rst_l single pulse, serve_dir = 1.
- With BALL_SIZE = 10 in PLAY: ball_x = 629 -> no pulse; ball_x = 630 -> pulse. With LEFT_LIMIT = 5 (separate config): ball_x = 6 -> no pulse; ball_x = 5 -> pulse.
- After a win_rst_l pulse, raise over_l in the SCORED cycle -> game_over = 1 one cycle after SERVE entry and ball_rst stays 1. start_btn -> score_clr pulse, game_over = 0, SERVE restarts.
- Deassert rst (drive low) during the SERVE count at tick 30, release, then press start -> a full 60 ticks are required again; no stray win pulse.
